// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared SAR types and constants
//
// Purpose: state encoding of the conversion sequencer and the default SAR
// result width shared with the SAR binary-search FSM.
// Ports: none (package).

package sar_pkg;

  localparam int unsigned SAR_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } sar_state_e;

endpackage

// File: rtl/sar_avg_accum.sv
// rtl/sar_avg_accum.sv - oversampling accumulator with shift-divide
//
// Purpose: sums 2^Log2N SAR results and produces their truncated mean.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   add_i          add data_i to the running sum this cycle
//   clear_i        drop the partial batch (wins over add_i)
//   data_i         SAR result to accumulate
//   done_o         this add completes the batch (combinational)
//   avg_o          latest mean, held between batches

module sar_avg_accum
  import sar_pkg::*;
#(
  parameter int unsigned Width = SAR_WIDTH,
  parameter int unsigned Log2N = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             add_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             done_o,
  output logic [Width-1:0] avg_o
);

  // Log2N extra bits make the sum of 2^Log2N full-scale samples unable to wrap.
  localparam int unsigned AccW = Width + Log2N;

  logic [AccW-1:0]  acc_q, acc_d, sum;
  logic [Log2N-1:0] cnt_q, cnt_d;
  logic [Width-1:0] avg_q, avg_d;

  assign sum    = acc_q + AccW'(data_i);
  // The counter only needs to reach N-1; the N-th add clears it.
  assign done_o = add_i && !clear_i && (cnt_q == '1);
  assign avg_o  = avg_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      if (done_o) begin
        avg_d = sum[AccW-1:Log2N];
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + Log2N'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
    end
  end

endmodule

// File: rtl/sar_avg_seq.sv
// rtl/sar_avg_seq.sv - SAR conversion sequencer and oversampling averager
//
// Purpose: issues periodic start pulses to the SAR, captures each result on
// the rising edge of eoc_i, averages 2^Log2N results and flags a SAR that
// never finishes.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           run enable
//   eoc_i          SAR end-of-conversion level (rising edge used)
//   result_i       SAR result, valid when eoc_i rises
//   start_o        one-cycle start pulse to the SAR
//   avg_o          latest averaged result
//   avg_valid_o    one-cycle strobe for a new avg_o
//   busy_o         sequencer not idle
//   timeout_o      sticky watchdog flag, cleared by en_i=0 in IDLE

module sar_avg_seq
  import sar_pkg::*;
#(
  parameter int unsigned Width         = SAR_WIDTH,
  parameter int unsigned Log2N         = 2,
  parameter int unsigned PeriodCycles  = 64,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             eoc_i,
  input  logic [Width-1:0] result_i,
  output logic             start_o,
  output logic [Width-1:0] avg_o,
  output logic             avg_valid_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int unsigned PW = $clog2(PeriodCycles);
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(PeriodCycles - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TimeoutCycles - 1);

  sar_state_e    state_q, state_d;
  logic          eoc_q;
  logic [PW-1:0] period_q, period_d, period_dec;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic          timeout_q, timeout_d;
  logic          avg_valid_q;
  logic          rise;
  logic          acc_add, acc_clear, acc_done;

  // A level still high from an earlier conversion never counts as a rise.
  assign rise       = eoc_i && !eoc_q;
  assign period_dec = (period_q == '0) ? '0 : period_q - PW'(1);
  assign to_inc     = to_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    to_d      = to_q;
    timeout_d = timeout_q;
    acc_add   = 1'b0;
    acc_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = START;
        end else begin
          timeout_d = 1'b0;
        end
      end
      START: begin
        period_d = PERIOD_LOAD;
        to_d     = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        period_d = period_dec;
        to_d     = to_inc;
        // The SAR cannot be aborted: en_i only matters once it finishes.
        if (rise) begin
          if (en_i) begin
            acc_add = 1'b1;
            state_d = HOLD;
          end else begin
            acc_clear = 1'b1;
            state_d   = IDLE;
          end
        end else if (to_inc == TO_LAST) begin
          timeout_d = 1'b1;
          acc_clear = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        period_d = period_dec;
        if (!en_i) begin
          acc_clear = 1'b1;
          state_d   = IDLE;
        end else if (period_dec == '0) begin
          // Leaving one cycle early makes START land exactly PeriodCycles
          // after the previous one.
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      eoc_q       <= 1'b0;
      period_q    <= '0;
      to_q        <= '0;
      timeout_q   <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      eoc_q       <= eoc_i;
      period_q    <= period_d;
      to_q        <= to_d;
      timeout_q   <= timeout_d;
      avg_valid_q <= acc_done;
    end
  end

  sar_avg_accum #(
    .Width(Width),
    .Log2N(Log2N)
  ) u_accum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .add_i  (acc_add),
    .clear_i(acc_clear),
    .data_i (result_i),
    .done_o (acc_done),
    .avg_o  (avg_o)
  );

  assign start_o     = (state_q == START);
  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = timeout_q;
  assign avg_valid_o = avg_valid_q;

endmodule
